// File: rtl/fm_stream_tx.sv
// Feature-map stream transmitter: buffers whole-depth pixel vectors in a small FIFO and emits them
// in raster order with a vs frame strobe and GAP-paced data_e strobes. Macro FM_TX_OVF_EN adds the sticky drop flag.
module fm_stream_tx #(
  parameter int FM_DEPTH   = 256,
  parameter int FM_WIDTH   = 14,
  parameter int GAP        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                mode,
  input  logic                                in_valid,
  input  logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] in_data,
  output logic                                in_ready,
  output logic                                data_e,
  output logic                                vs,
  output logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] data_out,
  output logic [4:0]                          row,
  output logic [4:0]                          col,
  output logic                                frame_done,
  output logic                                ovf,
  output logic [1:0]                          dbg_state
);

  localparam int             AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]     GAP_LAST = 4'(GAP-1);
  localparam logic [4:0]     LAST     = 5'(FM_WIDTH-1);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_t;

  // Handshake: a vector transfers on any rising edge with in_valid && in_ready; in_ready is
  // purely !full and never looks at the same-cycle pop.
  logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, fire;

  state_t        state_q;
  logic [3:0]    gap_q;
  logic [4:0]    row_q, col_q, row_d, col_d;
  logic          data_e_q, vs_q, frame_done_q;
  logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] data_out_q;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign fire     = mode && (state_q == STREAM) && (gap_q == GAP_LAST) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // row is the fast (inner) coordinate; col steps only when row wraps.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (row_q == LAST) begin
      row_d = '0;
      col_d = (col_q == LAST) ? 5'd0 : col_q + 5'd1;
    end else begin
      row_d = row_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      row_q        <= LAST;
      col_q        <= LAST;
      data_e_q     <= 1'b0;
      vs_q         <= 1'b0;
      frame_done_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      data_e_q     <= 1'b0;
      vs_q         <= 1'b0;
      frame_done_q <= 1'b0;
      // mode low freezes everything here; only the FIFO keeps accepting.
      if (mode) begin
        case (state_q)
          IDLE: begin
            if (!empty) begin
              state_q <= SYNC;
              vs_q    <= 1'b1;
              gap_q   <= '0;
            end
          end
          SYNC: begin
            state_q <= STREAM;
            gap_q   <= gap_q + 4'd1;
          end
          STREAM: begin
            if (fire) begin
              data_e_q   <= 1'b1;
              data_out_q <= mem_q[rd_ptr_q];
              gap_q      <= '0;
              row_q      <= row_d;
              col_q      <= col_d;
              if (row_d == LAST && col_d == LAST) state_q <= DONE;
            end else if (gap_q != GAP_LAST) begin
              gap_q <= gap_q + 4'd1;
            end
          end
          DONE: begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef FM_TX_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ovf_q <= 1'b0;
    else if (in_valid && full) ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign data_e     = data_e_q;
  assign vs         = vs_q;
  assign frame_done = frame_done_q;
  assign data_out   = data_out_q;
  assign row        = row_q;
  assign col        = col_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fm_stream_tx.sv
// Bench for fm_stream_tx: directed phases with randomized data/gaps/mode drops, checked every cycle
// against a behavioural model built from a pushed-vector queue and a pixel counter.
module tb_fm_stream_tx;

  localparam int FM_DEPTH   = 256;
  localparam int FM_WIDTH   = 14;
  localparam int GAP        = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int DW         = 8;
  localparam int VW         = FM_DEPTH * DW;
  localparam int NPIX       = FM_WIDTH * FM_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic [FM_DEPTH-1:0][DW-1:0] in_data = '0;
  logic in_ready, data_e, vs, frame_done, ovf;
  logic [FM_DEPTH-1:0][DW-1:0] data_out;
  logic [4:0] row, col;
  logic [1:0] dbg_state;

  fm_stream_tx #(
    .FM_DEPTH(FM_DEPTH), .FM_WIDTH(FM_WIDTH), .GAP(GAP),
    .FIFO_DEPTH(FIFO_DEPTH), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .data_e(data_e), .vs(vs), .data_out(data_out),
    .row(row), .col(col), .frame_done(frame_done), .ovf(ovf), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoring ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: lane0 got %0h expected %0h (vector differs)", name, act[DW-1:0], exp[DW-1:0]);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not seen within its cycle budget", name);
  endtask

  // ---------------- behavioural model ----------------
  logic [VW-1:0] exp_q[$];
  int   m_stage;   // 0 waiting for data, 1 frame strobe issued, 2 streaming, 3 frame complete
  int   m_since;   // active cycles since frame start / last pixel
  int   m_pix;     // pixels emitted in the current frame
  logic e_de, e_vs, e_fd, e_ovf;
  logic [4:0] e_row, e_col;
  logic [VW-1:0] e_dout;

  function void model_reset();
    exp_q.delete();
    m_stage = 0; m_since = 0; m_pix = 0;
    e_de = 1'b0; e_vs = 1'b0; e_fd = 1'b0; e_ovf = 1'b0;
    e_row = 5'(FM_WIDTH-1); e_col = 5'(FM_WIDTH-1);
    e_dout = '0;
  endfunction

  function void model_step();
    bit take;
    take = in_valid && (exp_q.size() < FIFO_DEPTH);
`ifdef FM_TX_OVF_EN
    if (in_valid && exp_q.size() >= FIFO_DEPTH) e_ovf = 1'b1;
`endif
    e_de = 1'b0; e_vs = 1'b0; e_fd = 1'b0;
    if (mode) begin
      if (m_stage == 0) begin
        if (exp_q.size() > 0) begin m_stage = 1; e_vs = 1'b1; m_since = 0; end
      end else if (m_stage == 1) begin
        m_stage = 2; m_since = 1;
      end else if (m_stage == 2) begin
        if (m_since >= GAP-1 && exp_q.size() > 0) begin
          e_de   = 1'b1;
          e_dout = exp_q.pop_front();
          e_row  = 5'(m_pix % FM_WIDTH);
          e_col  = 5'(m_pix / FM_WIDTH);
          m_pix++;
          m_since = 0;
          if (m_pix == NPIX) m_stage = 3;
        end else if (m_since < GAP-1) begin
          m_since++;
        end
      end else begin
        e_fd = 1'b1; m_stage = 0; m_pix = 0;
      end
    end
    if (take) exp_q.push_back(in_data);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare + event monitor ----------------
  int de_total = 0, vs_total = 0, fd_total = 0;
  int prev_de = -1, last_fd = -1, last_de = -1;
  bit t1 = 1'b0, t1_exact = 1'b1;
  int t1_idx = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_de = -1;
      last_fd = -1;
    end else begin
      chk("cycle de,vs,fd,ovf,rdy,row,col",
          {data_e, vs, frame_done, ovf, in_ready, row, col},
          {e_de, e_vs, e_fd, e_ovf, (exp_q.size() < FIFO_DEPTH), e_row, e_col});
      chk_vec("cycle data_out", data_out, e_dout);
      if (vs) begin
        vs_total++;
        chk("vs_with_de", data_e, 1'b0);
        if (last_fd >= 0) chk("vs_after_frame_done", (cyc > last_fd), 1'b1);
        prev_de = cyc;
      end
      if (data_e) begin
        de_total++;
        if (prev_de >= 0) begin
          chk("de_min_spacing", ((cyc - prev_de) >= GAP), 1'b1);
          if (t1 && (cyc - prev_de) != GAP) t1_exact = 1'b0;
        end
        prev_de = cyc;
        last_de = cyc;
        if (t1) begin
          chk("t1_lane0_index", data_out[0], t1_idx[7:0]);
          t1_idx++;
        end
      end
      if (frame_done) begin
        fd_total++;
        last_fd = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit abort = 1'b0;

  function automatic logic [VW-1:0] mk_vec(input int base);
    logic [FM_DEPTH-1:0][DW-1:0] t;
    for (int k = 0; k < FM_DEPTH; k++) t[k] = DW'(base + k);
    return t;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [FM_DEPTH-1:0][DW-1:0] t;
    for (int k = 0; k < FM_DEPTH; k++) t[k] = DW'($urandom);
    return t;
  endfunction

  function automatic bit sig(input int which);
    if (which == 0) return data_e;
    if (which == 1) return frame_done;
    return vs;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called aligned one time unit after a rising edge; returns the same way.
  task automatic push(input logic [VW-1:0] v, input int pre_idle, output int acc_cyc);
    bit ok;
    int budget;
    ok = 1'b0;
    budget = 300;
    if (pre_idle > 0) wait_cycles(pre_idle);
    in_valid = 1'b1;
    in_data  = v;
    while (!ok && budget > 0 && !abort) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    in_valid = 1'b0;
    acc_cyc  = cyc;
    if (!ok && !abort) fail_now("push_accept");
  endtask

  task automatic wait_until(input int which, input int budget, input string name, output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      #1;
      if (sig(which)) begin got = 1'b1; at = cyc; end
    end
    if (!got) fail_now(name);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data_e"}, data_e, 1'b0);
    chk({tag, "_vs"}, vs, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_ovf"}, ovf, 1'b0);
    chk({tag, "_row"}, row, 5'd13);
    chk({tag, "_col"}, col, 5'd13);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk_vec({tag, "_data_out"}, data_out, '0);
  endtask

  // ---------------- directed sequence ----------------
  int a0, a1, at, vs_at, d_at, n_vs0, n_de0, n_fd0, frz;
  bit found;
  logic [VW-1:0] held;

  initial begin
    rst_n = 1'b0;
    wait_cycles(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    wait_cycles(2);

    // Full frame with a producer that never starves the FIFO.
    mode = 1'b1;
    t1 = 1'b1; t1_idx = 0; t1_exact = 1'b1;
    n_vs0 = vs_total; n_de0 = de_total;
    for (int p = 0; p < NPIX; p++) push(mk_vec(p), 0, a0);
    wait_until(1, 2000, "t1_frame_done", at);
    t1 = 1'b0;
    chk("t1_vs_count", vs_total - n_vs0, 1);
    chk("t1_de_count", de_total - n_de0, NPIX);
    chk("t1_exact_gap", t1_exact, 1'b1);
    chk("t1_final_row", row, 5'd13);
    chk("t1_final_col", col, 5'd13);
    chk("t1_fd_after_last_de", at - last_de, 1);

    // Starved producer: one vector, long wait, then the next lands one cycle after its push.
    push(rnd_vec(), 0, a0);
    wait_until(0, 100, "t2_first_de", at);
    held = data_out;
    wait_cycles(20);
    chk_vec("t2_data_out_held", data_out, held);
    push(rnd_vec(), 0, a1);
    wait_until(0, 20, "t2_second_de", d_at);
    chk("t2_push_to_de_latency", d_at - a1, 1);

    // Freeze at pixel (5,3) while the producer keeps pushing.
    fork
      begin
        for (int p = 2; p < NPIX; p++) push(rnd_vec(), int'($urandom_range(0, 1)), a0);
      end
      begin
        found = 1'b0;
        for (int k = 0; k < NPIX && !found; k++) begin
          wait_until(0, 300, "t3_seek", at);
          if (row == 5'd5 && col == 5'd3) found = 1'b1;
        end
        if (!found) fail_now("t3_pixel_5_3");
        mode = 1'b0;
        frz = 0;
        for (int k = 0; k < 10; k++) begin
          wait_cycles(1);
          frz += int'(data_e);
        end
        chk("t3_no_de_frozen", frz, 0);
        mode = 1'b1;
        wait_until(0, 50, "t3_resume_de", at);
        chk("t3_resume_row", row, 5'd6);
        chk("t3_resume_col", col, 5'd3);
      end
    join
    wait_until(1, 2000, "t3_frame_done", at);

    // Fill the FIFO while frozen, then offer one extra vector.
    mode = 1'b0;
    for (int p = 0; p < FIFO_DEPTH; p++) push(mk_vec(100 + p), 0, a0);
    chk("t4_in_ready_full", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = mk_vec(77);
    wait_cycles(1);
    in_valid = 1'b0;
`ifdef FM_TX_OVF_EN
    chk("t4_ovf", ovf, 1'b1);
`else
    chk("t4_ovf", ovf, 1'b0);
`endif
    mode = 1'b1;

    // Reset in the middle of the frame at pixel (2,7).
    fork
      begin
        for (int p = FIFO_DEPTH; p < NPIX && !abort; p++) push(mk_vec(100 + p), 0, a0);
      end
      begin
        found = 1'b0;
        for (int k = 0; k < NPIX && !found; k++) begin
          wait_until(0, 300, "t5_seek", at);
          if (row == 5'd2 && col == 5'd7) found = 1'b1;
        end
        if (!found) fail_now("t5_pixel_2_7");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check_reset_vals("midreset");
      end
    join
    in_valid = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    abort = 1'b0;
    wait_cycles(2);

    // Fresh frame after reset, then a second one back-to-back with random gaps and mode drops.
    push(rnd_vec(), 0, a0);
    wait_until(2, 20, "t6_vs", vs_at);
    wait_until(0, 40, "t6_first_de", d_at);
    chk("t6_vs_before_de", (d_at > vs_at), 1'b1);
    chk("t6_first_row", row, 5'd0);
    chk("t6_first_col", col, 5'd0);
    n_fd0 = fd_total;
    fork
      begin
        for (int p = 1; p < 2 * NPIX; p++) push(rnd_vec(), int'($urandom_range(0, 2)), a0);
      end
      begin
        repeat (6) begin
          wait_cycles(int'($urandom_range(60, 200)));
          mode = 1'b0;
          wait_cycles(int'($urandom_range(1, 12)));
          mode = 1'b1;
        end
      end
    join
    for (int i = 0; i < 3000 && fd_total < n_fd0 + 2; i++) wait_cycles(1);
    chk("t6_frames_completed", fd_total - n_fd0, 2);
    wait_cycles(5);
    chk("end_in_ready", in_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fm_stream_tx.md
# fm_stream_tx

Feature-map stream transmitter that drives the pixel-serial interface consumed by the layer wrappers (`data_e`, `vs`, `data_in[FM_DEPTH]`). It accepts whole-depth pixel vectors from an upstream producer through a small valid/ready FIFO. It emits them in row-inner/col-outer raster order, with one `vs` pulse per frame and `data_e` pulses spaced so the receiver's 4-phase macro sequence always completes between pixels.

## Interface
- `FM_DEPTH`, 256, channels per pixel vector
- `FM_WIDTH`, 14, frame is `FM_WIDTH` x `FM_WIDTH` pixels
- `GAP`, 4, minimum cycles between successive `data_e` pulses; legal range 4..15
- `FIFO_DEPTH`, 4, input FIFO entries; power of two, minimum 2

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `mode`  in  1  0 = reload parameters (stream frozen), 1 = calculate
- `in_valid`  in  1  upstream vector valid
- `in_data`  in  `DATA_WIDTH` x `FM_DEPTH`  signed upstream pixel vector
- `in_ready`  out  1  FIFO not full
- `data_e`  out  1  one-cycle pixel strobe to the receiver
- `vs`  out  1  one-cycle frame-start strobe
- `data_out`  out  `DATA_WIDTH` x `FM_DEPTH`  signed pixel vector, held between strobes
- `row`, `col`  out  5 each  coordinate of the last emitted pixel
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame
- `ovf`  out  1  sticky drop flag (see Configuration)

## Operation
- FIFO: push on `in_valid && in_ready`. `in_ready = !full`; it does not depend on a same-cycle pop. Pop only on a `data_e` cycle.
- FSM states:
  - IDLE: counters parked at `row = col = FM_WIDTH-1`. Go to SYNC when `mode == 1` and the FIFO is non-empty.
  - SYNC: assert `vs` for exactly one cycle, load the gap counter to 0, go to STREAM.
  - STREAM: emit pixels. After pixel (`FM_WIDTH-1`, `FM_WIDTH-1`) is emitted, go to DONE.
  - DONE: assert `frame_done` for one cycle, go to IDLE.
- Gap counter in STREAM:
  - Counts up each cycle, saturating at `GAP-1`.
  - `data_e` asserts when the counter is `GAP-1`, the FIFO is non-empty and `mode == 1`.
  - On a `data_e` cycle the counter returns to 0.
  - FIFO empty at `GAP-1`: hold there; no strobe until data arrives.
- Each `data_e` cycle does three things together:
  - registers the FIFO head into `data_out`;
  - pops the FIFO;
  - advances the coordinates: `row` increments and wraps at `FM_WIDTH-1` to 0; `col` increments only on a `row` wrap and wraps likewise. The first pixel after `vs` is (0,0).
- `mode == 0` in any state: FSM, counters and `data_out` frozen; no `data_e`, `vs` or `frame_done`. FIFO pushes are still accepted. Resume exactly where frozen.
- Reset mid-frame: FIFO emptied, FSM to IDLE, partial frame discarded. The next frame starts with a fresh `vs`.

## Timing
- Reset values:
  - `data_e = 0`, `vs = 0`, `frame_done = 0`, `ovf = 0`
  - `data_out` all 0
  - `row = col = FM_WIDTH-1`
  - `in_ready = 1`
- All outputs except `in_ready` are registered. `data_out` changes only in the cycle `data_e` is high.
- Frame start:
  - `vs` at cycle T.
  - First `data_e` at T+GAP at the earliest.
  - Later strobes at least GAP cycles apart.
- Push into an empty FIFO while the counter is held at `GAP-1`: `data_e` on the next cycle (1-cycle latency).
- `vs` and `data_e` are never high in the same cycle. Successive frames: `frame_done` at cycle F, next `vs` no earlier than F+1.
- Full FIFO with a pop in the same cycle: no push that cycle; `in_ready` rises the following cycle.

## Configuration
- `FM_TX_OVF_EN` defined:
  - `ovf` sets on any cycle with `in_valid && !in_ready` and stays set until reset.
  - The offending vector is dropped.
- Not defined:
  - `ovf` tied to 0 and the detection logic is removed.
  - Behaviour of all other outputs is identical.

## Test plan
- Reset, `mode=1`, push 196 vectors (channel k = pixel index + k) with `in_valid` held high:
  - exactly one `vs`, 196 `data_e` pulses, each exactly 4 cycles apart with GAP=4;
  - `data_out[0]` matches the pixel index;
  - final `row = col = 13`;
  - `frame_done` one cycle after the last strobe.
- Starve the producer: push 1 vector, wait 20 cycles, push the next:
  - the second `data_e` arrives exactly 1 cycle after the second push;
  - `data_out` is stable throughout the wait.
- Drop `mode` for 10 cycles mid-frame at pixel (5,3):
  - no strobes during the freeze;
  - the next strobe emits (6,3);
  - FIFO contents are preserved.
- Fill the FIFO (4 entries) before `mode=1`:
  - `in_ready = 0`;
  - with `FM_TX_OVF_EN` defined, an extra `in_valid` sets `ovf = 1` and the 5th vector is never emitted.
- Assert `rst_n` low at pixel (2,7):
  - all outputs return to their reset values immediately;
  - after release and a fresh push, `vs` precedes the first strobe and that strobe is (0,0).
- Two back-to-back frames:
  - second `vs` no earlier than 1 cycle after `frame_done`;
  - `vs` and `data_e` never coincide.
